matmul_tile_engine: RTL and testbench
=====================================

Name: matmul_tile_engine

Overview:
- Parametrised GRID_SIZE x GRID_SIZE signed matrix-multiply engine for the accelerator's OP_MATMUL instruction.
- Reads operands A and B from the scratchpad buffer and writes C = A x B back to it.
- Adds accumulate, saturate and transpose-B modes. Driven by the instruction sequencer through a start/busy/done handshake.

Parameters:
- NUM_SIZE, 16: word width; signed two's complement.
- BUFFER_LEN, 32: scratchpad depth in words.
- GRID_SIZE, 2: matrix dimension N. Legal range is 2..8.
- ADDR_WIDTH, $clog2(BUFFER_LEN): derived; not overridden.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: launch request. Sampled only in IDLE.
- src_a, input, ADDR_WIDTH: base address of A (row-major).
- src_b, input, ADDR_WIDTH: base address of B (row-major).
- dst, input, ADDR_WIDTH: base address of C (row-major).
- mode, input, 3: bit0 accumulate, bit1 saturate, bit2 transpose B.
- mem_rd_addr, output, ADDR_WIDTH: scratchpad read address. Data returns one cycle later.
- mem_rd_data, input, NUM_SIZE: scratchpad read data.
- mem_wr_en, output, 1: scratchpad write strobe.
- mem_wr_addr, output, ADDR_WIDTH: write address.
- mem_wr_data, output, NUM_SIZE: write data.
- busy, output, 1: operation in progress.
- done, output, 1: one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0. State goes to IDLE. Internal A/B registers and the accumulator are cleared.
- Reset mid-operation aborts the operation: no further writes, and done is not pulsed.
- Launch:
  - start=1 in IDLE at cycle t0 latches src_a, src_b, dst and mode.
  - busy=1 from t0+1 until the cycle done is asserted. busy=0 in that cycle.
  - start while busy is ignored and its operands are not latched.
- States: IDLE -> LOAD -> MAC -> WRITE -> (MAC | FINISH) -> IDLE.
- LOAD (2N^2+1 cycles):
  - Issues reads of A[0..N^2-1], then B[0..N^2-1], one per cycle.
  - Captures each word one cycle after issue into internal N x N register arrays. The last cycle is a drain.
- MAC (N cycles per output element C[i][j], row-major order):
  - acc += A[i][k] * Bsel[k][j] for k = 0..N-1.
  - Bsel = B, or B transposed when mode[2]=1.
  - Accumulator width is 2*NUM_SIZE + $clog2(N) + 1, so it cannot overflow.
- Accumulate mode (mode[0]=1):
  - The read of dst+i*N+j is issued in the first MAC cycle.
  - The data is captured in the second MAC cycle, sign-extended and added to acc.
  - With mode[0]=0, no dst reads are issued.
- WRITE (1 cycle):
  - mem_wr_en=1, mem_wr_addr = dst+i*N+j, mem_wr_data = result.
  - Accumulator is cleared.
  - Goes to the next element, or to FINISH after element N^2-1.
- Result width:
  - mode[1]=0: result is the low NUM_SIZE bits of acc (wrap).
  - mode[1]=1: result is clamped to [-2^(NUM_SIZE-1), 2^(NUM_SIZE-1)-1].
- FINISH: done=1 and busy=0 for one cycle, then IDLE. A start in that same cycle is ignored.
- Latency: done is asserted at cycle t0 + 2 + 2N^2 + N^2(N+1). For N=2 this is t0+22, regardless of mode.
- Address arithmetic is modulo 2^ADDR_WIDTH; a block crossing the top of the buffer wraps to 0.
- Overlap between dst and src: operands are fully buffered before the first write, so overlap is safe.
- Overlap between dst blocks across accumulate reads: each C element is read before it is written, so this is also safe.
- mem_wr_en is 0 in every state except WRITE. mem_rd_addr is don't-care outside LOAD and the first MAC cycle.

Decomposition:
- Shared package accel_pkg holds:
  - opcode constants OP_MATMUL=6'd1 and OP_HALT=6'd10;
  - instruction field positions: opcode [23:18], src_a [17:13], src_b [12:8], dst [7:3], mode [2:0];
  - mode bit indices MODE_ACC, MODE_SAT, MODE_TRB;
  - the state enum.
- One sub-module, mac_unit: signed multiply-accumulate with clear and accumulate-in input, plus a wrap/saturate output stage.

Test Plan:
- Basic, N=2, mode 0:
  - Stimulus: mem[0..3]={3,1,4,1}, mem[4..7]={2,1,7,8}, src_a=0, src_b=4, dst=8, start.
  - Response: mem[8..11]={13,11,15,12}; done at t0+22; exactly 4 writes.
- Accumulate (mode=1):
  - Stimulus: same operands, mem[8..11] preloaded with {1,1,1,1}.
  - Response: mem[8..11]={14,12,16,13}.
- Transpose (mode=4):
  - Stimulus: same operands.
  - Response: mem[8..11]={7,29,9,36}.
- Saturation:
  - Stimulus: A row 0 = {16'h7FFF,16'h7FFF}, B col 0 = {2,2}.
  - Response: mode 0 writes C[0][0]=16'hFFFC; mode 2 writes 16'h7FFF.
- Wrap addressing:
  - Stimulus: src_a=30 with A stored in mem[30,31,0,1].
  - Response: read addresses are 30,31,0,1; result matches the basic test.
- Handshake:
  - Stimulus: second start at t0+5 with dst=16; separately, rst at t0+12.
  - Response: the second start is ignored, with no writes to 16..19. After the reset: busy=0, done is never pulsed, no writes after reset, and a following start behaves normally.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator definitions.
// Contents:
// - instruction opcodes and field positions;
// - matmul mode bit indices;
// - matmul engine state encoding.
package accel_pkg;

  localparam logic [5:0] OP_MATMUL = 6'd1;
  localparam logic [5:0] OP_HALT   = 6'd10;

  localparam int OPC_MSB  = 23;
  localparam int OPC_LSB  = 18;
  localparam int SRCA_MSB = 17;
  localparam int SRCA_LSB = 13;
  localparam int SRCB_MSB = 12;
  localparam int SRCB_LSB = 8;
  localparam int DST_MSB  = 7;
  localparam int DST_LSB  = 3;
  localparam int MODE_MSB = 2;
  localparam int MODE_LSB = 0;

  localparam int MODE_ACC = 0;
  localparam int MODE_SAT = 1;
  localparam int MODE_TRB = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MAC    = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/matmul_tile_engine_mac.sv
// mac_unit: signed multiply-accumulate with output stage.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   clr           - clear accumulator (takes priority over en)
//   en            - acc += a*b (+ add_val when add_en)
//   a, b          - signed operands
//   add_en        - also add sign-extended add_val this cycle
//   add_val       - signed accumulate-in value
//   sat           - 1: clamp result to NUM_SIZE signed range, 0: wrap
//   result        - NUM_SIZE-bit view of the accumulator
module mac_unit
  import accel_pkg::*;
#(
  parameter int NUM_SIZE = 16,
  parameter int ACC_W    = 34
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [NUM_SIZE-1:0] a,
  input  logic [NUM_SIZE-1:0] b,
  input  logic                add_en,
  input  logic [NUM_SIZE-1:0] add_val,
  input  logic                sat,
  output logic [NUM_SIZE-1:0] result
);

  localparam int PW = 2 * NUM_SIZE;

  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add_ext;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-NUM_SIZE:0] acc_hi;
  logic                    ovf;

  // A 2*NUM_SIZE product always holds the full signed product.
  assign a_ext    = {{NUM_SIZE{a[NUM_SIZE-1]}}, a};
  assign b_ext    = {{NUM_SIZE{b[NUM_SIZE-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign add_ext  = add_en ? {{(ACC_W-NUM_SIZE){add_val[NUM_SIZE-1]}}, add_val} : '0;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext + add_ext;
    end
  end

  // Value fits in NUM_SIZE signed bits iff the bits from the result sign upward agree.
  assign acc_hi = acc[ACC_W-1:NUM_SIZE-1];
  assign ovf    = !((&acc_hi) || (~|acc_hi));

  always_comb begin
    result = acc[NUM_SIZE-1:0];
    if (sat && ovf) begin
      result = acc[ACC_W-1] ? {1'b1, {(NUM_SIZE-1){1'b0}}} : {1'b0, {(NUM_SIZE-1){1'b1}}};
    end
  end

endmodule

// File: rtl/matmul_tile_engine.sv
// matmul_tile_engine: GRID_SIZE x GRID_SIZE signed C = A x B on the scratchpad.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start                    - launch request, honoured only in IDLE
//   src_a, src_b, dst        - row-major base addresses of A, B, C
//   mode                     - [0] accumulate into C, [1] saturate, [2] transpose B
//   mem_rd_addr/mem_rd_data  - scratchpad read port, data one cycle after address
//   mem_wr_en/addr/data      - scratchpad write port
//   busy                     - operation in progress
//   done                     - one-cycle completion pulse
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | streaming A then B into local registers, last cycle drains the read pipe
// MAC     | GRID_SIZE multiply-accumulate steps for element (row, col)
// WRITE   | store element, clear accumulator, advance element
// FINISH  | done pulse, busy low
module matmul_tile_engine
  import accel_pkg::*;
#(
  parameter int NUM_SIZE   = 16,
  parameter int BUFFER_LEN = 32,
  parameter int GRID_SIZE  = 2,
  parameter int ADDR_WIDTH = $clog2(BUFFER_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_a,
  input  logic [ADDR_WIDTH-1:0] src_b,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [2:0]            mode,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [NUM_SIZE-1:0]   mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [NUM_SIZE-1:0]   mem_wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int NN    = GRID_SIZE * GRID_SIZE;
  localparam int EW    = $clog2(NN);
  localparam int RW    = $clog2(GRID_SIZE);
  localparam int LW    = $clog2(2 * NN + 1);
  localparam int ACC_W = 2 * NUM_SIZE + $clog2(GRID_SIZE) + 1;

  localparam logic [RW-1:0] K_LAST  = RW'(GRID_SIZE - 1);
  localparam logic [EW-1:0] E_LAST  = EW'(NN - 1);
  localparam logic [LW-1:0] LD_LAST = LW'(2 * NN);
  localparam logic [LW-1:0] LD_NN   = LW'(NN);

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] src_a_r, src_b_r, dst_r;
  logic [2:0]            mode_r;
  logic [LW-1:0]         ld_cnt;
  logic [LW-1:0]         cap_idx;
  logic [RW-1:0]         row, col, k;
  logic [EW-1:0]         elem;
  logic [EW-1:0]         a_idx, b_idx;
  logic [NUM_SIZE-1:0]   a_reg [NN];
  logic [NUM_SIZE-1:0]   b_reg [NN];
  logic [NUM_SIZE-1:0]   result;
  logic                  mac_en, mac_clr, acc_in_en;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOAD;
      ST_LOAD:   if (ld_cnt == LD_LAST) state_nxt = ST_MAC;
      ST_MAC:    if (k == K_LAST) state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = (elem == E_LAST) ? ST_FINISH : ST_MAC;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Word read in LOAD cycle c arrives in cycle c+1.
  assign cap_idx = ld_cnt - LW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      src_a_r <= '0;
      src_b_r <= '0;
      dst_r   <= '0;
      mode_r  <= '0;
      ld_cnt  <= '0;
      row     <= '0;
      col     <= '0;
      k       <= '0;
      elem    <= '0;
      for (int n = 0; n < NN; n++) begin
        a_reg[n] <= '0;
        b_reg[n] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_a_r <= src_a;
            src_b_r <= src_b;
            dst_r   <= dst;
            mode_r  <= mode;
            ld_cnt  <= '0;
            row     <= '0;
            col     <= '0;
            k       <= '0;
            elem    <= '0;
          end
        end
        ST_LOAD: begin
          ld_cnt <= ld_cnt + LW'(1);
          if (ld_cnt != '0) begin
            if (cap_idx < LD_NN) a_reg[EW'(cap_idx)] <= mem_rd_data;
            else                 b_reg[EW'(cap_idx - LD_NN)] <= mem_rd_data;
          end
        end
        ST_MAC: begin
          k <= (k == K_LAST) ? '0 : k + RW'(1);
        end
        ST_WRITE: begin
          elem <= elem + EW'(1);
          if (col == K_LAST) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Transpose picks B[col][k] instead of B[k][col].
  assign a_idx = EW'(row) * EW'(GRID_SIZE) + EW'(k);
  assign b_idx = mode_r[MODE_TRB] ? EW'(col) * EW'(GRID_SIZE) + EW'(k)
                                  : EW'(k) * EW'(GRID_SIZE) + EW'(col);

  assign mac_en    = (state == ST_MAC);
  assign mac_clr   = (state == ST_WRITE);
  // The C read issued at k=0 returns at k=1.
  assign acc_in_en = mac_en && mode_r[MODE_ACC] && (k == RW'(1));

  mac_unit #(
    .NUM_SIZE (NUM_SIZE),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (a_reg[a_idx]),
    .b       (b_reg[b_idx]),
    .add_en  (acc_in_en),
    .add_val (mem_rd_data),
    .sat     (mode_r[MODE_SAT]),
    .result  (result)
  );

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    case (state)
      ST_LOAD: begin
        busy = 1'b1;
        if (ld_cnt < LD_NN) mem_rd_addr = src_a_r + ADDR_WIDTH'(ld_cnt);
        else                mem_rd_addr = src_b_r + ADDR_WIDTH'(ld_cnt - LD_NN);
      end
      ST_MAC: begin
        busy = 1'b1;
        if (mode_r[MODE_ACC] && (k == '0)) mem_rd_addr = dst_r + ADDR_WIDTH'(elem);
      end
      ST_WRITE: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_wr_addr = dst_r + ADDR_WIDTH'(elem);
        mem_wr_data = result;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Bench for matmul_tile_engine (N=2, 16-bit words, 32-word scratchpad).
module tb_matmul_tile_engine;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  src_a = '0, src_b = '0, dst = '0;
  logic [2:0]  mode = '0;
  logic [4:0]  mem_rd_addr, mem_wr_addr;
  logic [15:0] mem_rd_data, mem_wr_data;
  logic        mem_wr_en, busy, done;

  always #5 clk = ~clk;

  matmul_tile_engine #(
    .NUM_SIZE   (16),
    .BUFFER_LEN (32),
    .GRID_SIZE  (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .src_a       (src_a),
    .src_b       (src_b),
    .dst         (dst),
    .mode        (mode),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done)
  );

  logic [15:0] mem    [32];
  logic [15:0] shadow [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)          mem[pl_addr] <= pl_data;
    else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_rd_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_count = 0;
  logic [20:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every DUT write must match the next expected (addr, data).
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      logic [20:0] e;
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_wr_addr), 32'(e[20:16]));
        check("wr_data", 32'(mem_wr_data), 32'(e[15:0]));
      end
    end
  end

  task automatic preload(input logic [4:0] a, input logic [15:0] v);
    @(negedge clk);
    pl_addr = a;
    pl_data = v;
    pl_en   = 1'b1;
    shadow[a] = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic preload4(input logic [4:0] base, input logic [15:0] v0, v1, v2, v3);
    preload(base, v0);
    preload(base + 5'd1, v1);
    preload(base + 5'd2, v2);
    preload(base + 5'd3, v3);
  endtask

  function automatic logic [15:0] model(input int i, input int j, input logic [4:0] sa,
                                        input logic [4:0] sb, input logic [4:0] d,
                                        input logic [2:0] m);
    longint acc = 0;
    longint av, bv;
    for (int kk = 0; kk < N; kk++) begin
      av = longint'($signed(shadow[(int'(sa) + i * N + kk) % 32]));
      if (m[2]) bv = longint'($signed(shadow[(int'(sb) + j * N + kk) % 32]));
      else      bv = longint'($signed(shadow[(int'(sb) + kk * N + j) % 32]));
      acc += av * bv;
    end
    if (m[0]) acc += longint'($signed(shadow[(int'(d) + i * N + j) % 32]));
    if (m[1] && acc > 32767)  return 16'h7FFF;
    if (m[1] && acc < -32768) return 16'h8000;
    return acc[15:0];
  endfunction

  task automatic push_expected(input logic [4:0] sa, sb, d, input logic [2:0] m, input int count);
    for (int e = 0; e < count; e++) begin
      logic [4:0] a5;
      a5 = d + 5'(e);
      exp_q.push_back({a5, model(e / N, e % N, sa, sb, d, m)});
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] sa, sb, d, input logic [2:0] m,
                        input bit fin_start, input bit second_start);
    int t0, n;
    bit got_done;
    logic [4:0] exp_ra;
    got_done = 0;
    n = 0;
    push_expected(sa, sb, d, m, N * N);
    wr_count = 0;
    @(negedge clk);
    src_a = sa; src_b = sb; dst = d; mode = m; start = 1'b1;
    t0 = cyc;
    while (!got_done && n < 60) begin
      @(negedge clk);
      n = cyc - t0;
      if (n == 1) begin
        start = 1'b0;
        src_a = 5'd7; src_b = 5'd9; dst = 5'd3; mode = ~m;
        check({name, "_busy_start"}, 32'(busy), 32'd1);
      end
      if (n >= 1 && n <= 2 * N * N) begin
        exp_ra = (n <= N * N) ? sa + 5'(n - 1) : sb + 5'(n - 1 - N * N);
        check({name, "_rd_addr"}, 32'(mem_rd_addr), 32'(exp_ra));
      end
      if (second_start && n == 5) begin
        start = 1'b1; dst = 5'd16; src_a = 5'd4; src_b = 5'd0; mode = 3'd0;
      end
      if (second_start && n == 6) start = 1'b0;
      if (done === 1'b1) begin
        got_done = 1;
        check({name, "_done_latency"}, 32'(n), 32'd22);
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        if (fin_start) start = 1'b1;
      end
    end
    if (!got_done) check({name, "_done_timeout"}, 32'(n), 32'd22);
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_write_count"}, 32'(wr_count), 32'(N * N));
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic abort_op(input logic [4:0] sa, sb, d);
    int t0, n;
    bit saw_done;
    saw_done = 0;
    n = 0;
    // Element 0 is written in cycle t0+12, the same cycle the reset is raised.
    push_expected(sa, sb, d, 3'd0, 1);
    wr_count = 0;
    @(negedge clk);
    src_a = sa; src_b = sb; dst = d; mode = 3'd0; start = 1'b1;
    t0 = cyc;
    while (n < 45) begin
      @(negedge clk);
      n = cyc - t0;
      if (n == 1) start = 1'b0;
      if (n == 12) rst = 1'b1;
      if (n == 13) begin
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
      end
      if (done === 1'b1) saw_done = 1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_write_count", 32'(wr_count), 32'd1);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_c(input string name, input logic [4:0] base, input logic [15:0] v0, v1, v2, v3);
    @(negedge clk);
    check({name, "_c00"}, 32'(mem[base]), 32'(v0));
    check({name, "_c01"}, 32'(mem[base + 5'd1]), 32'(v1));
    check({name, "_c10"}, 32'(mem[base + 5'd2]), 32'(v2));
    check({name, "_c11"}, 32'(mem[base + 5'd3]), 32'(v3));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("rst_wr_data", 32'(mem_wr_data), 32'd0);
    check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    rst = 1'b0;

    preload4(5'd0, 16'd3, 16'd1, 16'd4, 16'd1);
    preload4(5'd4, 16'd2, 16'd1, 16'd7, 16'd8);
    run_op("basic", 5'd0, 5'd4, 5'd8, 3'd0, 1'b1, 1'b0);
    check_c("basic", 5'd8, 16'd13, 16'd11, 16'd15, 16'd12);

    preload4(5'd8, 16'd1, 16'd1, 16'd1, 16'd1);
    run_op("accum", 5'd0, 5'd4, 5'd8, 3'd1, 1'b0, 1'b0);
    check_c("accum", 5'd8, 16'd14, 16'd12, 16'd16, 16'd13);

    run_op("trans", 5'd0, 5'd4, 5'd8, 3'd4, 1'b0, 1'b0);
    check_c("trans", 5'd8, 16'd7, 16'd29, 16'd9, 16'd36);

    preload4(5'd0, 16'h7FFF, 16'h7FFF, 16'd0, 16'd0);
    preload4(5'd4, 16'd2, 16'd0, 16'd2, 16'd0);
    run_op("sat_off", 5'd0, 5'd4, 5'd8, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("sat_off_c00", 32'(mem[8]), 32'h0000FFFC);
    run_op("sat_on", 5'd0, 5'd4, 5'd8, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("sat_on_c00", 32'(mem[8]), 32'h00007FFF);

    preload(5'd30, 16'd3);
    preload(5'd31, 16'd1);
    preload(5'd0, 16'd4);
    preload(5'd1, 16'd1);
    preload4(5'd4, 16'd2, 16'd1, 16'd7, 16'd8);
    run_op("wrap", 5'd30, 5'd4, 5'd8, 3'd0, 1'b0, 1'b0);
    check_c("wrap", 5'd8, 16'd13, 16'd11, 16'd15, 16'd12);

    preload4(5'd0, 16'd3, 16'd1, 16'd4, 16'd1);
    run_op("restart", 5'd0, 5'd4, 5'd8, 3'd0, 1'b0, 1'b1);

    abort_op(5'd0, 5'd4, 5'd12);
    run_op("post_rst", 5'd0, 5'd4, 5'd20, 3'd0, 1'b0, 1'b0);
    check_c("post_rst", 5'd20, 16'd13, 16'd11, 16'd15, 16'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
